vec_cache_sram_burst_ctrl: RTL and testbench

- Initiator side of the per-SRAM read/write command interface (sram_inst_cmd_t: addr[8:0], byte_sel[1:0], mode).
- Accepts one burst request at a time and expands it into single-beat 32-bit read_vld/read_cmd or write_vld/write_cmd issues.
- Captures the returned rd_data one cycle after each read issue into a credit-protected return FIFO; write data comes from a valid/ready stream.
- Sits between the vector-cache datapath and one SRAM instance.

---
 rtl/vec_cache_sram_burst_ctrl_if.sv | 59 +++++
 rtl/vec_cache_sram_burst_ctrl.sv | 154 +++++++++++++++
 tb/tb_vec_cache_sram_burst_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_cache_sram_burst_ctrl_if.sv
// rtl/vec_cache_sram_burst_ctrl_if.sv - request, stream and SRAM command bundle for vec_cache_sram_burst_ctrl
// The master modport is the controller side; the slave modport is the datapath/SRAM side.
interface vec_cache_sram_burst_ctrl_if #(
  parameter int LEN_W = 4
);
  typedef struct packed {
    logic [8:0] addr;
    logic [1:0] byte_sel;
    logic       mode;
  } sram_inst_cmd_t;

  logic             req_vld;
  logic             req_rdy;
  logic             req_wr;
  logic [8:0]       req_addr;
  logic [1:0]       req_byte_sel;
  logic             req_mode;
  logic [LEN_W-1:0] req_len;

  logic             wdata_vld;
  logic             wdata_rdy;
  logic [31:0]      wdata;

  logic             rdata_vld;
  logic             rdata_rdy;
  logic [31:0]      rdata;
  logic             rdata_last;

  logic             wr_done;

  logic             read_vld;
  sram_inst_cmd_t   read_cmd;
  logic             write_vld;
  sram_inst_cmd_t   write_cmd;
  logic [31:0]      wr_data;
  logic [31:0]      rd_data;

  modport master (
    input  req_vld, req_wr, req_addr, req_byte_sel, req_mode, req_len,
    input  wdata_vld, wdata,
    input  rdata_rdy,
    input  rd_data,
    output req_rdy, wdata_rdy,
    output rdata_vld, rdata, rdata_last,
    output wr_done,
    output read_vld, read_cmd, write_vld, write_cmd, wr_data
  );

  modport slave (
    output req_vld, req_wr, req_addr, req_byte_sel, req_mode, req_len,
    output wdata_vld, wdata,
    output rdata_rdy,
    output rd_data,
    input  req_rdy, wdata_rdy,
    input  rdata_vld, rdata, rdata_last,
    input  wr_done,
    input  read_vld, read_cmd, write_vld, write_cmd, wr_data
  );
endinterface

// File: rtl/vec_cache_sram_burst_ctrl.sv
// rtl/vec_cache_sram_burst_ctrl.sv - expands burst requests into single-beat SRAM reads/writes with a credit-protected return FIFO
// Optional stall counter built when VEC_SRAM_BURST_PERF_EN is defined; otherwise perf_stall_cnt is tied to 0.
module vec_cache_sram_burst_ctrl #(
  parameter int LEN_W       = 4,
  parameter int RFIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  vec_cache_sram_burst_ctrl_if.master bus,
  output logic [15:0]                 perf_stall_cnt
);
  localparam int PW = $clog2(RFIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(RFIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t           state;
  logic [8:0]       cur_addr;
  logic [1:0]       cur_sel;
  logic             cur_mode;
  logic [LEN_W-1:0] beats_left;

  logic             read_vld_d;
  logic             last_d;
  logic             wr_done_q;

  logic [31:0]      fifo_data [RFIFO_DEPTH];
  logic             fifo_last [RFIFO_DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    fifo_count;
  logic             fifo_empty;

  logic             pop;
  logic             credit_ok;
  logic             rd_issue;
  logic             wr_issue;
  logic             last_beat;
  logic [8:0]       nxt_addr;
  logic [1:0]       nxt_sel;

  always_comb begin
    fifo_empty = (fifo_count == '0);
    pop        = !fifo_empty && bus.rdata_rdy;
    // Slots already used (entries plus the one being captured) must leave room,
    // counting the slot freed by a pop in this same cycle.
    credit_ok  = ({1'b0, fifo_count} + {{CW{1'b0}}, read_vld_d}) < (DEPTH_W + {{CW{1'b0}}, pop});
    rd_issue   = (state == RD) && credit_ok;
    wr_issue   = (state == WR) && bus.wdata_vld;
    last_beat  = (beats_left == '0);
    nxt_sel    = cur_sel;
    nxt_addr   = cur_addr;
    if (cur_mode) begin
      nxt_addr = cur_addr + 9'd1;
    end else begin
      nxt_sel = cur_sel + 2'd1;
      if (cur_sel == 2'd3) nxt_addr = cur_addr + 9'd1;
    end
  end

  assign bus.req_rdy    = (state == IDLE);
  assign bus.wdata_rdy  = (state == WR);
  assign bus.read_vld   = rd_issue;
  assign bus.write_vld  = wr_issue;
  assign bus.read_cmd   = rd_issue ? {cur_addr, cur_sel, cur_mode} : '0;
  assign bus.write_cmd  = wr_issue ? {cur_addr, cur_sel, cur_mode} : '0;
  assign bus.wr_data    = bus.wdata;
  assign bus.wr_done    = wr_done_q;
  assign bus.rdata_vld  = !fifo_empty;
  assign bus.rdata      = fifo_empty ? 32'h0 : fifo_data[rptr];
  assign bus.rdata_last = !fifo_empty && fifo_last[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_addr   <= '0;
      cur_sel    <= '0;
      cur_mode   <= 1'b0;
      beats_left <= '0;
      read_vld_d <= 1'b0;
      last_d     <= 1'b0;
      wr_done_q  <= 1'b0;
    end else begin
      read_vld_d <= rd_issue;
      last_d     <= rd_issue && last_beat;
      wr_done_q  <= wr_issue && last_beat;
      case (state)
        IDLE: begin
          if (bus.req_vld) begin
            cur_addr   <= bus.req_addr;
            cur_sel    <= bus.req_byte_sel;
            cur_mode   <= bus.req_mode;
            beats_left <= bus.req_len;
            state      <= bus.req_wr ? WR : RD;
          end
        end
        RD, WR: begin
          if (rd_issue || wr_issue) begin
            if (last_beat) begin
              state <= IDLE;
            end else begin
              cur_addr   <= nxt_addr;
              cur_sel    <= nxt_sel;
              beats_left <= beats_left - LEN_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (read_vld_d) wptr <= wptr + PW'(1);
      if (pop)        rptr <= rptr + PW'(1);
      case ({read_vld_d, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (read_vld_d) begin
      fifo_data[wptr] <= bus.rd_data;
      fifo_last[wptr] <= last_d;
    end
  end

`ifdef VEC_SRAM_BURST_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (((state == RD && !credit_ok) || (state == WR && !bus.wdata_vld)) &&
                 (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign perf_stall_cnt = stall_q;
`else
  assign perf_stall_cnt = 16'h0;
`endif
endmodule

// File: tb/tb_vec_cache_sram_burst_ctrl.sv
// tb/tb_vec_cache_sram_burst_ctrl.sv - scoreboard bench for vec_cache_sram_burst_ctrl
module tb_vec_cache_sram_burst_ctrl;
  localparam int LEN_W = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] perf_stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // {wr, addr, byte_sel, mode, data, last}
  logic [45:0] exp_cmd[$];
  // {rdata, last}
  logic [32:0] exp_rd[$];

  int          rd_issue_cnt = 0;
  int          rd_pushed    = 0;
  int          rd_beats     = 0;
  logic        rd_pend      = 1'b0;
  logic [11:0] rd_pend_cmd  = '0;
  logic        wr_done_exp  = 1'b0;
  logic        rdy_rand     = 1'b0;
  logic [45:0] mon_e;
  logic [32:0] mon_r;

  vec_cache_sram_burst_ctrl_if #(.LEN_W(LEN_W)) bus();

  vec_cache_sram_burst_ctrl #(
    .LEN_W       (LEN_W),
    .RFIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .perf_stall_cnt (perf_stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sram_word(input logic [11:0] c);
    return {8'hC5, 3'b000, c, 9'h0A5};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SRAM model: data for the command seen last cycle, garbage otherwise.
  always @(posedge clk) begin
    #1;
    bus.rd_data = rd_pend ? sram_word(rd_pend_cmd) : 32'hDEADBEEF;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      rd_pend     = 1'b0;
      wr_done_exp = 1'b0;
    end else begin
      check("rw_excl", 64'(bus.read_vld & bus.write_vld), 64'd0);
      check("wr_done", 64'(bus.wr_done), 64'(wr_done_exp));
      wr_done_exp = 1'b0;
      rd_pend     = 1'b0;
      if (bus.read_vld || bus.write_vld) begin
        if (exp_cmd.size() == 0) begin
          check("issue_extra", 64'(exp_cmd.size()), 64'd1);
        end else begin
          mon_e = exp_cmd.pop_front();
          check("issue", 64'({bus.write_vld, bus.write_vld ? bus.write_cmd : bus.read_cmd,
                              bus.write_vld ? bus.wr_data : 32'h0}), 64'(mon_e[45:1]));
          check("unused_cmd", 64'(bus.write_vld ? bus.read_cmd : bus.write_cmd), 64'd0);
          if (bus.write_vld) wr_done_exp = mon_e[0];
        end
        if (bus.read_vld) begin
          rd_pend     = 1'b1;
          rd_pend_cmd = bus.read_cmd;
          rd_issue_cnt++;
        end
      end
      if (bus.rdata_vld && bus.rdata_rdy) begin
        if (exp_rd.size() == 0) begin
          check("rdata_extra", 64'(exp_rd.size()), 64'd1);
        end else begin
          mon_r = exp_rd.pop_front();
          check("rdata", 64'({bus.rdata, bus.rdata_last}), 64'(mon_r));
        end
        rd_beats++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) bus.rdata_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic send_req(input bit wr, input logic [8:0] addr, input logic [1:0] sel,
                          input bit mode, input int len, input logic [31:0] base);
    logic [8:0] a = addr;
    logic [1:0] s = sel;
    int         n = 0;
    for (int i = 0; i <= len; i++) begin
      if (wr) begin
        exp_cmd.push_back({1'b1, a, s, mode, base + 32'(i), i == len});
      end else begin
        exp_cmd.push_back({1'b0, a, s, mode, 32'h0, 1'b0});
        exp_rd.push_back({sram_word({a, s, mode}), i == len});
        rd_pushed++;
      end
      if (mode) begin
        a = a + 9'd1;
      end else begin
        if (s == 2'd3) a = a + 9'd1;
        s = s + 2'd1;
      end
    end
    bus.req_wr       = wr;
    bus.req_addr     = addr;
    bus.req_byte_sel = sel;
    bus.req_mode     = mode;
    bus.req_len      = LEN_W'(len);
    bus.req_vld      = 1'b1;
    while (!bus.req_rdy && n < 300) begin
      tick();
      n++;
    end
    check("req_rdy", 64'(bus.req_rdy), 64'd1);
    if (wr) check("b2b_reads_done", 64'(rd_issue_cnt), 64'(rd_pushed));
    tick();
    bus.req_vld = 1'b0;
  endtask

  task automatic drive_wdata(input int len, input int gap, input logic [31:0] base);
    for (int i = 0; i <= len; i++) begin
      for (int g = 0; g < gap; g++) begin
        bus.wdata_vld = 1'b0;
        tick();
      end
      bus.wdata_vld = 1'b1;
      bus.wdata     = base + 32'(i);
      tick();
    end
    bus.wdata_vld = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_cmd.size() != 0 || exp_rd.size() != 0) && n < 1000) begin
      tick();
      n++;
    end
    tick();
    tick();
    check(tag, 64'(exp_cmd.size() + exp_rd.size()), 64'd0);
  endtask

  initial begin
    int          snap;
    int          snapb;
    logic [15:0] psnap;
    rst_n            = 1'b0;
    bus.req_vld      = 1'b0;
    bus.req_wr       = 1'b0;
    bus.req_addr     = '0;
    bus.req_byte_sel = '0;
    bus.req_mode     = 1'b0;
    bus.req_len      = '0;
    bus.wdata_vld    = 1'b0;
    bus.wdata        = '0;
    bus.rdata_rdy    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_rdy", 64'(bus.req_rdy), 64'd1);
    check("rst_read_vld", 64'(bus.read_vld), 64'd0);
    check("rst_write_vld", 64'(bus.write_vld), 64'd0);
    check("rst_rdata_vld", 64'(bus.rdata_vld), 64'd0);
    check("rst_rdata_last", 64'(bus.rdata_last), 64'd0);
    check("rst_wr_done", 64'(bus.wr_done), 64'd0);
    check("rst_cmds", 64'({bus.read_cmd, bus.write_cmd}), 64'd0);
    check("rst_perf", 64'(perf_stall_cnt), 64'd0);
    rst_n = 1'b1;
    tick();

    snap = rd_issue_cnt;
    send_req(1'b0, 9'd5, 2'd2, 1'b0, 3, 32'h0);
    repeat (4) tick();
    check("t1_consec_issues", 64'(rd_issue_cnt - snap), 64'd4);
    drain("t1_drain");

    send_req(1'b1, 9'd511, 2'd1, 1'b1, 2, 32'hA0);
    drive_wdata(2, 0, 32'hA0);
    drain("t2_drain");

    bus.rdata_rdy = 1'b0;
    snap  = rd_issue_cnt;
    snapb = rd_beats;
    send_req(1'b0, 9'd200, 2'd0, 1'b1, 15, 32'h0);
    repeat (20) tick();
    check("t3_stall_issues", 64'(rd_issue_cnt - snap), 64'(DEPTH));
    check("t3_rdata_vld", 64'(bus.rdata_vld), 64'd1);
    bus.rdata_rdy = 1'b1;
    drain("t3_drain");
    check("t3_beats", 64'(rd_beats - snapb), 64'd16);

    psnap = perf_stall_cnt;
    send_req(1'b1, 9'd300, 2'd3, 1'b0, 3, 32'h1000);
    drive_wdata(3, 1, 32'h1000);
    drain("t4_drain");
`ifdef VEC_SRAM_BURST_PERF_EN
    check("t4_perf", 64'(perf_stall_cnt - psnap), 64'd4);
`else
    check("t4_perf_off", 64'(perf_stall_cnt), 64'd0);
`endif

    bus.rdata_rdy = 1'b0;
    send_req(1'b0, 9'd100, 2'd0, 1'b0, 15, 32'h0);
    repeat (3) tick();
    check("t5_pre_rdata_vld", 64'(bus.rdata_vld), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rdata_vld", 64'(bus.rdata_vld), 64'd0);
    check("t5_req_rdy", 64'(bus.req_rdy), 64'd1);
    check("t5_read_vld", 64'(bus.read_vld), 64'd0);
    check("t5_read_cmd", 64'(bus.read_cmd), 64'd0);
    exp_cmd.delete();
    exp_rd.delete();
    rd_pushed = rd_issue_cnt;
    repeat (2) tick();
    rst_n         = 1'b1;
    bus.rdata_rdy = 1'b1;
    tick();
    snapb = rd_beats;
    send_req(1'b0, 9'd7, 2'd3, 1'b0, 0, 32'h0);
    drain("t5_drain");
    check("t5_one_beat", 64'(rd_beats - snapb), 64'd1);

    send_req(1'b0, 9'd511, 2'd2, 1'b0, 5, 32'h0);
    send_req(1'b1, 9'd510, 2'd2, 1'b0, 4, 32'h2000);
    drive_wdata(4, 0, 32'h2000);
    drain("t6_drain");

    rdy_rand = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bit          wr;
      int          len;
      logic [31:0] base;
      wr   = 1'($urandom_range(0, 1));
      len  = int'($urandom_range(0, 7));
      base = $urandom;
      send_req(wr, 9'($urandom_range(0, 511)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), len, base);
      if (wr) drive_wdata(len, int'($urandom_range(0, 2)), base);
    end
    drain("t7_drain");
    rdy_rand      = 1'b0;
    bus.rdata_rdy = 1'b1;
    drain("t7_final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
